// File: rtl/tru_nbit_serial_if.sv
// Operand/result bundle for the digit-serial subtractor.
// The master drives the request; the slave returns status and result.
interface tru_nbit_serial_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             bo;
  logic             ovf;

  modport master (output start, A, B, bin, input busy, done, D, bo, ovf);
  modport slave  (input start, A, B, bin, output busy, done, D, bo, ovf);
endinterface

// File: rtl/tru_nbit_serial.sv
// Digit-serial subtractor: D = A - B - bin, DIGIT bits per clock, LSB-first.
// Also produces the unsigned borrow-out and the two's-complement overflow flag.
module tru_nbit_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  tru_nbit_serial_if.slave  bus
);
  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("tru_nbit_serial: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             a_msb;
  logic             b_msb;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] d_q;
  logic             bo_q;
  logic             ovf_q;

  logic [DIGIT-1:0] dig;
  logic             br;
  logic             br_out;
  logic [WIDTH-1:0] diff_next;
  logic             last;

  // Ripple-borrow chain over the current (lowest) digit of the shifted operands.
  always_comb begin
    dig = '0;
    br  = borrow_q;
    for (int i = 0; i < int'(DIGIT); i++) begin
      dig[i] = a_sh[i] ^ b_sh[i] ^ br;
      br     = (~a_sh[i] & b_sh[i]) | (~(a_sh[i] ^ b_sh[i]) & br);
    end
    br_out    = br;
    diff_next = (diff_q >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
    last      = (cnt == CW'(N - 1));
  end

  // Control, operand shifters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      d_q      <= '0;
      bo_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh     <= bus.A;
            b_sh     <= bus.B;
            borrow_q <= bus.bin;
            a_msb    <= bus.A[WIDTH-1];
            b_msb    <= bus.B[WIDTH-1];
            diff_q   <= '0;
            cnt      <= '0;
            busy_q   <= 1'b1;
            state    <= RUN;
          end else begin
            state    <= IDLE;
          end
        end
        RUN: begin
          a_sh     <= a_sh >> DIGIT;
          b_sh     <= b_sh >> DIGIT;
          diff_q   <= diff_next;
          borrow_q <= br_out;
          cnt      <= cnt + CW'(1);
          if (last) begin
            d_q    <= diff_next;
            bo_q   <= br_out;
            ovf_q  <= (a_msb != b_msb) && (diff_next[WIDTH-1] != a_msb);
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.D    = d_q;
  assign bus.bo   = bo_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_tru_nbit_serial.sv
// Bench for tru_nbit_serial: four instances (DIGIT = 1, 2, 4, 8) share one stimulus
// and are compared against an arithmetic reference model.
module tb_tru_nbit_serial;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_s;
  logic         bin_s;
  logic [W-1:0] a_s;
  logic [W-1:0] b_s;

  logic [3:0]   busy_w;
  logic [3:0]   done_w;
  logic [3:0]   bo_w;
  logic [3:0]   ovf_w;
  logic [W-1:0] d_w [4];

  logic [W-1:0] prev_d   [4];
  logic         prev_bo  [4];
  logic         prev_ovf [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    tru_nbit_serial_if #(.WIDTH(W)) bus_i ();
    assign bus_i.start = start_s;
    assign bus_i.A     = a_s;
    assign bus_i.B     = b_s;
    assign bus_i.bin   = bin_s;
    assign busy_w[g]   = bus_i.busy;
    assign done_w[g]   = bus_i.done;
    assign bo_w[g]     = bus_i.bo;
    assign ovf_w[g]    = bus_i.ovf;
    assign d_w[g]      = bus_i.D;
    tru_nbit_serial #(.WIDTH(W), .DIGIT(1 << g)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_i)
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                                output logic [W-1:0] d, output logic bo, output logic ov);
    logic [W:0] t;
    int         s;
    t  = {1'b0, a} - {1'b0, b} - (W+1)'(bi);
    s  = int'($signed(a)) - int'($signed(b)) - int'(bi);
    d  = t[W-1:0];
    bo = t[W];
    ov = (s < -128) || (s > 127);
  endfunction

  task automatic clear_prev();
    for (int j = 0; j < 4; j++) begin
      prev_d[j] = '0; prev_bo[j] = 1'b0; prev_ovf[j] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start_s = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_prev();
  endtask

  // One start pulse; every instance is tracked cycle by cycle until its result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    logic [W-1:0] ed;
    logic         eb, eo;
    int           n;
    model(a, b, bi, ed, eb, eo);
    @(negedge clk);
    a_s = a; b_s = b; bin_s = bi; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      for (int j = 0; j < 4; j++) begin
        n = 8 >> j;
        if (c < n) begin
          chk($sformatf("d%0d_busy_c%0d", j, c), 32'(busy_w[j]), 32'd1);
          chk($sformatf("d%0d_done_c%0d", j, c), 32'(done_w[j]), 32'd0);
          chk($sformatf("d%0d_hold_d", j), 32'(d_w[j]), 32'(prev_d[j]));
          chk($sformatf("d%0d_hold_flags", j), 32'({bo_w[j], ovf_w[j]}),
              32'({prev_bo[j], prev_ovf[j]}));
        end else if (c == n) begin
          chk($sformatf("d%0d_done", j), 32'(done_w[j]), 32'd1);
          chk($sformatf("d%0d_busy_end", j), 32'(busy_w[j]), 32'd0);
          chk($sformatf("d%0d_D a=%0h b=%0h bin=%0b", j, a, b, bi), 32'(d_w[j]), 32'(ed));
          chk($sformatf("d%0d_bo", j), 32'(bo_w[j]), 32'(eb));
          chk($sformatf("d%0d_ovf", j), 32'(ovf_w[j]), 32'(eo));
          prev_d[j] = ed; prev_bo[j] = eb; prev_ovf[j] = eo;
        end else if (c == n + 1) begin
          chk($sformatf("d%0d_done_1cyc", j), 32'({busy_w[j], done_w[j]}), 32'd0);
        end
      end
      if (c == 1) begin
        a_s = ~a; b_s = ~b; bin_s = ~bi;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start_s = 1'b0; bin_s = 1'b0; a_s = '0; b_s = '0;
    clear_prev();
    repeat (2) @(negedge clk);
    for (int j = 0; j < 4; j++)
      chk($sformatf("d%0d_reset", j),
          32'({busy_w[j], done_w[j], d_w[j], bo_w[j], ovf_w[j]}), 32'd0);
    rst = 1'b0;

    // Directed arithmetic corners
    run_op(8'h05, 8'h03, 1'b0);
    chk("basic_D", 32'(d_w[1]), 32'h02);
    run_op(8'h00, 8'h01, 1'b0);
    chk("wrap_D_bo", 32'({d_w[1], bo_w[1], ovf_w[1]}), 32'({8'hFF, 1'b1, 1'b0}));
    run_op(8'h10, 8'h0F, 1'b1);
    chk("bin_D_bo", 32'({d_w[1], bo_w[1]}), 32'({8'h00, 1'b0}));
    run_op(8'h80, 8'h01, 1'b0);
    chk("ovf_neg", 32'({d_w[1], bo_w[1], ovf_w[1]}), 32'({8'h7F, 1'b0, 1'b1}));
    run_op(8'h7F, 8'hFF, 1'b0);
    chk("ovf_pos", 32'({d_w[1], bo_w[1], ovf_w[1]}), 32'({8'h80, 1'b1, 1'b1}));

    // start held through RUN, operands changed mid-run; back-to-back from DONE
    do_reset();
    @(negedge clk);
    a_s = 8'h05; b_s = 8'h03; bin_s = 1'b0; start_s = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= 9; c++) begin
      if (c == 4) begin
        chk("b2b_done1", 32'({busy_w[1], done_w[1]}), 32'b01);
        chk("b2b_D1", 32'(d_w[1]), 32'h02);
      end else if (c == 9) begin
        chk("b2b_done2", 32'({busy_w[1], done_w[1]}), 32'b01);
        chk("b2b_D2", 32'({d_w[1], bo_w[1], ovf_w[1]}), 32'({8'h99, 1'b0, 1'b0}));
      end else begin
        chk($sformatf("b2b_busy_c%0d", c), 32'({busy_w[1], done_w[1]}), 32'b10);
        if (c > 4) chk($sformatf("b2b_hold_c%0d", c), 32'(d_w[1]), 32'h02);
      end
      if (c == 0) begin a_s = 8'hAA; b_s = 8'h11; end
      if (c == 5) start_s = 1'b0;
      @(negedge clk);
    end

    // Asynchronous reset in the middle of RUN
    do_reset();
    run_op(8'h00, 8'h01, 1'b0);
    @(negedge clk);
    a_s = 8'h10; b_s = 8'h0F; bin_s = 1'b0; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int j = 0; j < 4; j++)
      chk($sformatf("d%0d_async_rst", j),
          32'({busy_w[j], done_w[j], d_w[j], bo_w[j], ovf_w[j]}), 32'd0);
    #1 rst = 1'b0;
    clear_prev();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("no_done_after_rst_c%0d", c), 32'({busy_w, done_w}), 32'd0);
    end
    run_op(8'h37, 8'h12, 1'b0);
    chk("after_rst_D", 32'(d_w[1]), 32'h25);

    // Randomized operations on all four digit widths
    for (int k = 0; k < 1000; k++)
      run_op(W'($urandom), W'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
